decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined RV32I/RV32E instruction decode stage with valid/ready handshakes on both sides and a two-entry skid buffer. It sits between fetch and execute. It splits a 32-bit instruction into opcode, register indices, funct fields and a sign-extended immediate, carries the PC alongside, and flags illegal encodings. It improves on the previous combinational decoder in four ways: parametrised XLEN and register-file depth, STORE support, legality checking, and full-throughput back-pressure.

## Interface
- XLEN, 32: datapath width for PC and immediate; must be ≥ 32.
- REG_ADDR_WIDTH, 5: register index width; 5 = RV32I, 4 = RV32E.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle available.
- out_ready  in  1  execute accepts the bundle.
- out_pc  out  XLEN  PC passed through.
- op  out  7  inst[6:0].
- rd / rs1 / rs2  out  REG_ADDR_WIDTH each  low bits of inst[11:7] / [19:15] / [24:20].
- funct3  out  3  inst[14:12].
- funct7  out  7  inst[31:25].
- imm  out  XLEN  sign-extended immediate.
- illegal  out  1  encoding not supported.

## Operation
- Decode is combinational from in_inst and in_pc. The bundle is captured into an output register, with one skid entry behind it.
- Immediates are built as a 32-bit value, then sign-extended from bit 31 to XLEN:
  - LUI, AUIPC: U-type, {inst[31:12], 12'b0}.
  - JAL: J-type, {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - JALR, LOAD, OP-IMM: I-type, inst[31:20].
  - STORE: S-type, {inst[31:25], inst[11:7]}.
  - BRANCH: B-type, {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - OP (0110011) and all others: imm = 0.
- illegal = 1 if any of the following holds:
  - inst[1:0] ≠ 11.
  - The opcode is not in {LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, OP-IMM, OP}.
  - JALR with funct3 ≠ 000.
  - LOAD with funct3 ∈ {011, 110, 111}.
  - STORE with funct3 ≥ 011.
  - BRANCH with funct3 ∈ {010, 011}.
  - OP-IMM with funct3 = 001 and funct7 ≠ 0.
  - OP-IMM with funct3 = 101 and funct7 ∉ {0000000, 0100000}.
  - OP with funct7 ∉ {0000000, 0100000}.
  - OP with funct7 = 0100000 and funct3 ∉ {000, 101}.
  - For REG_ADDR_WIDTH < 5 only: a register field the format uses has a bit set at or above REG_ADDR_WIDTH.
    - U/J formats use rd.
    - I format uses rd and rs1.
    - S/B formats use rs1 and rs2.
    - R format uses all three.
- Illegal instructions still flow through the pipeline with illegal = 1. Execute raises the trap.
- Skid buffer behaviour:
  - The output register loads when it is empty or when out_ready = 1.
  - The skid entry captures an accepted input only when the output register is held (out_valid & ~out_ready).
  - The skid entry drains into the output register first, before any new input.
  - Bundle order is strictly preserved.
- in_ready = ~skid_valid. It is a registered flag, not combinational from out_ready.
- flush:
  - Clears both valid bits on the next edge.
  - Any in_valid in the same cycle is dropped.
  - flush has priority over every other event.

## Timing
- Latency: an instruction accepted at edge N is on the outputs with out_valid = 1 after edge N, i.e. one cycle.
- Throughput: one instruction per cycle while out_ready = 1.
- Back-pressure: with out_ready = 0, two more instructions are accepted. in_ready falls after the edge that fills the skid entry.
- Recovery: in_ready returns to 1 one cycle after out_ready rises.
- Handshake rules:
  - Transfer occurs when valid & ready at a rising edge.
  - out_* fields hold stable while out_valid & ~out_ready.
- Reset (async, while rst = 1): out_valid = 0, skid_valid = 0, in_ready = 1, and every bundle output (out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal) = 0.
- Reset asserted mid-stream discards all buffered instructions. The first edge after deassertion may accept input.
- Simultaneous flush and out_ready: the bundle counts as consumed, and nothing new loads.

## Test plan
- Defaults, in_inst = 0xFFF00093 (addi x1, x0, -1), out_ready = 1:
  - Next cycle: op = 0x13, rd = 1, rs1 = 0, funct3 = 0, imm = 0xFFFFFFFF, illegal = 0, out_pc = in_pc.
- 0x008000EF (jal x1, 8) → imm = 8. 0xFE000EE3 (beq x0, x0, -4) → imm = 0xFFFFFFFC. 0x00112223 (sw x1, 4(x2)) → imm = 4, rs1 = 2, rs2 = 1. All with illegal = 0.
- Back-pressure: stream 4 instructions with out_ready = 0.
  - After 2 acceptances, in_ready = 0 and the output holds #1.
  - Raise out_ready: #1, #2, #3, #4 appear in order on consecutive cycles, with no loss or duplication.
- 0x40001033 (funct7 = 0100000, funct3 = 001) → illegal = 1. 0x00000000 → illegal = 1. 0x40000033 (sub) → illegal = 0.
- REG_ADDR_WIDTH = 4:
  - 0x00000833 (add x16, x0, x0) → illegal = 1.
  - 0x000007B3 (add x15) → illegal = 0, rd = 15.
- Flush with 2 entries buffered and in_valid = 1 → out_valid = 0 and in_ready = 1 next cycle, no bundle emitted. Reset asserted mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
//   RV32I/RV32E decode stage between fetch and execute. An instruction word is
//   decoded combinationally into a bundle (pc, opcode, register indices, funct
//   fields, sign-extended immediate, illegal flag). The bundle goes into an
//   output register with a single skid entry behind it, so the stage can run
//   at full throughput while in_ready stays a registered signal.
//
//   Parameters
//     XLEN            datapath width for pc and immediate (>= 32)
//     REG_ADDR_WIDTH  register index width (5 = RV32I, 4 = RV32E)
//
//   Ports
//     clk, rst        clock, asynchronous active-high reset
//     flush           synchronous kill of everything buffered and the input
//     in_valid/ready  fetch-side handshake, in_inst / in_pc payload
//     out_valid/ready execute-side handshake
//     out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal  decoded bundle
module decode_stage #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_inst,
  input  logic [XLEN-1:0]           in_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [6:0]                op,
  output logic [REG_ADDR_WIDTH-1:0] rd,
  output logic [REG_ADDR_WIDTH-1:0] rs1,
  output logic [REG_ADDR_WIDTH-1:0] rs2,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [XLEN-1:0]           imm,
  output logic                      illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]           pc;
    logic [6:0]                op;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [XLEN-1:0]           imm;
    logic                      illegal;
  } bundle_t;

  bundle_t    dec;
  bundle_t    out_q;
  bundle_t    skid_q;
  logic       out_valid_q;
  logic       skid_valid_q;

  logic [31:0] imm32;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        unsupported;
  logic        bad_funct;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic        rd_hi;
  logic        rs1_hi;
  logic        rs2_hi;
  logic        reg_bad;
  logic        f7_std;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    opc         = in_inst[6:0];
    f3          = in_inst[14:12];
    f7          = in_inst[31:25];
    imm32       = '0;
    unsupported = 1'b0;
    bad_funct   = 1'b0;
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    f7_std      = (f7 == 7'b0000000) || (f7 == 7'b0100000);

    // Register field bits at or above REG_ADDR_WIDTH; always zero for RV32I.
    rd_hi  = |(in_inst[11:7]  >> REG_ADDR_WIDTH);
    rs1_hi = |(in_inst[19:15] >> REG_ADDR_WIDTH);
    rs2_hi = |(in_inst[24:20] >> REG_ADDR_WIDTH);

    case (opc)
      OPC_LUI, OPC_AUIPC: begin
        imm32  = {in_inst[31:12], 12'b0};
        use_rd = 1'b1;
      end
      OPC_JAL: begin
        imm32  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                  in_inst[30:21], 1'b0};
        use_rd = 1'b1;
      end
      OPC_JALR: begin
        imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        bad_funct = (f3 != 3'b000);
      end
      OPC_LOAD: begin
        imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        bad_funct = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        imm32     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        bad_funct = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        imm32     = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        bad_funct = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_OPIMM: begin
        imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        // Shift-immediates carry a funct7 in the upper immediate bits.
        bad_funct = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                    ((f3 == 3'b101) && !f7_std);
      end
      OPC_OP: begin
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        bad_funct = !f7_std ||
                    ((f7 == 7'b0100000) && (f3 != 3'b000) && (f3 != 3'b101));
      end
      default: unsupported = 1'b1;
    endcase

    reg_bad = (use_rd && rd_hi) || (use_rs1 && rs1_hi) || (use_rs2 && rs2_hi);

    dec         = '0;
    dec.pc      = in_pc;
    dec.op      = opc;
    dec.rd      = in_inst[7  +: REG_ADDR_WIDTH];
    dec.rs1     = in_inst[15 +: REG_ADDR_WIDTH];
    dec.rs2     = in_inst[20 +: REG_ADDR_WIDTH];
    dec.funct3  = f3;
    dec.funct7  = f7;
    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = (in_inst[1:0] != 2'b11) || unsupported || bad_funct || reg_bad;
  end

  // ---------------------------------------------------------------------------
  // Output register + skid entry
  // ---------------------------------------------------------------------------
  // in_ready depends only on the skid flag, so an accepted input always has a
  // place to go: the output register if it frees up, otherwise the skid entry.
  assign in_ready = ~skid_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (~out_valid_q | out_ready) begin
      if (skid_valid_q) begin
        // Older bundle first; in_ready is low, so no input arrives this edge.
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_valid) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_valid & ~skid_valid_q) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_q.pc;
  assign op        = out_q.op;
  assign rd        = out_q.rd;
  assign rs1       = out_q.rs1;
  assign rs2       = out_q.rs2;
  assign funct3    = out_q.funct3;
  assign funct7    = out_q.funct7;
  assign imm       = out_q.imm;
  assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        illegal;

  // RV32E instance, driven in lockstep with the same inputs
  logic        e_in_ready;
  logic        e_out_valid;
  logic [31:0] e_out_pc;
  logic [6:0]  e_op;
  logic [3:0]  e_rd, e_rs1, e_rs2;
  logic [2:0]  e_funct3;
  logic [6:0]  e_funct7;
  logic [31:0] e_imm;
  logic        e_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .illegal(illegal)
  );

  decode_stage #(.XLEN(32), .REG_ADDR_WIDTH(4)) dut_e (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .op(e_op), .rd(e_rd), .rs1(e_rs1), .rs2(e_rs2), .funct3(e_funct3),
    .funct7(e_funct7), .imm(e_imm), .illegal(e_illegal)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        ill;
    logic        ill_e;
  } exp_t;

  exp_t tbl[11];
  exp_t sb[$];
  exp_t cur;
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   xfers    = 0;

  function automatic exp_t mk(logic [31:0] inst, logic [6:0] o, logic [4:0] d,
                              logic [4:0] s1, logic [4:0] s2, logic [2:0] f3,
                              logic [6:0] f7, logic [31:0] im, logic il, logic ile);
    exp_t e;
    e.inst = inst; e.pc = '0; e.op = o; e.rd = d; e.rs1 = s1; e.rs2 = s2;
    e.f3 = f3; e.f7 = f7; e.imm = im; e.ill = il; e.ill_e = ile;
    return e;
  endfunction

  function automatic exp_t at_pc(exp_t e, logic [31:0] pc);
    exp_t r = e;
    r.pc = pc;
    return r;
  endfunction

  // Scoreboard: push on accepted input, pop on consumed output
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        xfers++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: unexpected bundle pc=%h got none expected", out_pc);
        end else begin
          mon_e = sb.pop_front();
          if ({out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal} !==
              {mon_e.pc, mon_e.op, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3,
               mon_e.f7, mon_e.imm, mon_e.ill}) begin
            n_fail++;
            $display("FAIL bundle: got pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b expected pc=%h op=%h rd=%0d rs1=%0d rs2=%0d f3=%0d f7=%h imm=%h ill=%b",
                     out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal,
                     mon_e.pc, mon_e.op, mon_e.rd, mon_e.rs1, mon_e.rs2, mon_e.f3,
                     mon_e.f7, mon_e.imm, mon_e.ill);
          end
          n_checks++;
          if ({e_out_valid, e_illegal, e_rd} !== {1'b1, mon_e.ill_e, mon_e.rd[3:0]}) begin
            n_fail++;
            $display("FAIL rv32e: got valid=%b ill=%b rd=%0d expected valid=1 ill=%b rd=%0d (inst %h)",
                     e_out_valid, e_illegal, e_rd, mon_e.ill_e, mon_e.rd[3:0], mon_e.inst);
          end
        end
      end
      if (flush) sb.delete();
      if (in_valid && in_ready && !flush) sb.push_back(cur);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input exp_t e);
    bit ok = 0;
    cur      = e;
    in_inst  = e.inst;
    in_pc    = e.pc;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      cyc();
    end
    in_valid = 1'b0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 20 cycles, expected acceptance (pc %h)", e.pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = '0; in_pc = '0; cur = tbl[0];
    #2;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_flags: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    n_checks++;
    if ({out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal} !== '0) begin
      n_fail++;
      $display("FAIL reset_bundle: got pc=%h op=%h imm=%h ill=%b expected all zero", out_pc, op, imm, illegal);
    end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_decode();
    out_ready = 1'b1;
    send(at_pc(tbl[0], 32'h0000_1000));
    n_checks++;
    if ({out_valid, out_pc} !== {1'b1, 32'h0000_1000}) begin
      n_fail++;
      $display("FAIL latency: got valid=%b pc=%h expected valid=1 pc=00001000", out_valid, out_pc);
    end
    for (int i = 1; i < 11; i++) send(at_pc(tbl[i], 32'h0000_1000 + 32'(4 * i)));
    cyc();
    cyc();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL decode_drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back();
    int x0;
    exp_t e[4];
    for (int i = 0; i < 4; i++) e[i] = at_pc(tbl[i], 32'h0000_2000 + 32'(16 * i));
    out_ready = 1'b0;
    send(e[0]);
    send(e[1]);
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready: got in_ready=%b expected 0", in_ready);
    end
    cur = e[2]; in_inst = e[2].inst; in_pc = e[2].pc; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({in_ready, out_valid, out_pc, op} !== {1'b0, 1'b1, e[0].pc, e[0].op}) begin
        n_fail++;
        $display("FAIL bp_hold: got ready=%b valid=%b pc=%h op=%h expected ready=0 valid=1 pc=%h op=%h",
                 in_ready, out_valid, out_pc, op, e[0].pc, e[0].op);
      end
    end
    x0 = xfers;
    out_ready = 1'b1;
    cyc();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_recover: got in_ready=%b expected 1", in_ready);
    end
    cyc();
    cur = e[3]; in_inst = e[3].inst; in_pc = e[3].pc;
    cyc();
    in_valid = 1'b0;
    cyc();
    n_checks++;
    if ((xfers - x0) != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_stream: got %0d transfers %0d pending expected 4 transfers 0 pending",
               xfers - x0, sb.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(at_pc(tbl[4], 32'h0000_3000));
    send(at_pc(tbl[5], 32'h0000_3004));
    cur = at_pc(tbl[6], 32'h0000_3008);
    in_inst = cur.inst; in_pc = cur.pc; in_valid = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_state: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_empty: got out_valid=%b expected 0", out_valid);
      end
    end
    // flush together with out_ready: current bundle consumed, new input dropped
    send(at_pc(tbl[7], 32'h0000_3100));
    cur = at_pc(tbl[8], 32'h0000_3104);
    in_inst = cur.inst; in_pc = cur.pc; in_valid = 1'b1; flush = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, 32'(sb.size())} !== {2'b01, 32'd0}) begin
      n_fail++;
      $display("FAIL flush_consume: got valid=%b ready=%b pending=%0d expected valid=0 ready=1 pending=0",
               out_valid, in_ready, sb.size());
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(at_pc(tbl[9], 32'h0000_4000));
    send(at_pc(tbl[3], 32'h0000_4004));
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++;
    if ({out_valid, in_ready, out_pc, op, rd, rs1, rs2, funct3, funct7, imm, illegal} !==
        {1'b0, 1'b1, 97'd0}) begin
      n_fail++;
      $display("FAIL rst_mid: got valid=%b ready=%b pc=%h op=%h imm=%h ill=%b expected valid=0 ready=1 all zero",
               out_valid, in_ready, out_pc, op, imm, illegal);
    end
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    send(at_pc(tbl[2], 32'h0000_4100));
    n_checks++;
    if ({out_valid, out_pc, imm} !== {1'b1, 32'h0000_4100, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL rst_restart: got valid=%b pc=%h imm=%h expected valid=1 pc=00004100 imm=fffffffc",
               out_valid, out_pc, imm);
    end
    cyc();
  endtask

  initial begin
    //           inst          op     rd  rs1 rs2 f3  f7     imm           ill ill_e
    tbl[0]  = mk(32'hFFF00093, 7'h13, 1,  0,  31, 0, 7'h7F, 32'hFFFFFFFF, 0, 0); // addi x1,x0,-1
    tbl[1]  = mk(32'h008000EF, 7'h6F, 1,  0,  8,  0, 7'h00, 32'h00000008, 0, 0); // jal x1,8
    tbl[2]  = mk(32'hFE000EE3, 7'h63, 29, 0,  0,  0, 7'h7F, 32'hFFFFFFFC, 0, 0); // beq x0,x0,-4
    tbl[3]  = mk(32'h00112223, 7'h23, 4,  2,  1,  2, 7'h00, 32'h00000004, 0, 0); // sw x1,4(x2)
    tbl[4]  = mk(32'h40001033, 7'h33, 0,  0,  0,  1, 7'h20, 32'h00000000, 1, 1); // bad funct7/funct3
    tbl[5]  = mk(32'h00000000, 7'h00, 0,  0,  0,  0, 7'h00, 32'h00000000, 1, 1); // all zero
    tbl[6]  = mk(32'h40000033, 7'h33, 0,  0,  0,  0, 7'h20, 32'h00000000, 0, 0); // sub
    tbl[7]  = mk(32'h00000833, 7'h33, 16, 0,  0,  0, 7'h00, 32'h00000000, 0, 1); // add x16
    tbl[8]  = mk(32'h000007B3, 7'h33, 15, 0,  0,  0, 7'h00, 32'h00000000, 0, 0); // add x15
    tbl[9]  = mk(32'h123450B7, 7'h37, 1,  8,  3,  5, 7'h09, 32'h12345000, 0, 0); // lui x1
    tbl[10] = mk(32'h00003003, 7'h03, 0,  0,  0,  3, 7'h00, 32'h00000000, 1, 1); // load f3=011
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL final_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
